// File: rtl/text_writer.sv
// -----------------------------------------------------------------------------
// text_writer
//
// Character-stream front end for a text-mode video RAM. Bytes arriving on a
// valid/ready handshake are either written at the cursor or interpreted as
// control codes: CR (0x0D), LF (0x0A), BS (0x08), FF (0x0C). The screen is
// ROWS rows of 32 cells; cell (col,row) lives at address row*32+col.
//
// Overflow past the last row depends on the build macro TEXT_WRITER_SCROLL_EN:
//   defined   : the screen scrolls up one row (read/write copy, then the last
//               row is blanked) and the cursor stays on the last row.
//   undefined : the cursor wraps to row 0 and only row 0 is blanked; the copy
//               states do not exist in this build.
//
// Reset (asynchronous, active-high) parks the block in the full-screen clear,
// which runs to completion after release before any byte is accepted.
//
// Ports
//   clk_sys     in   1   clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   in_data     in   8   character or control code
//   in_valid    in   1   in_data is valid
//   in_ready    out  1   byte accepted this cycle when in_valid is high
//   v_ram_a     out  11  video RAM address
//   v_ram_do    out  8   video RAM write data
//   v_ram_we    out  1   video RAM write enable
//   v_ram_di    in   8   video RAM read data (one cycle after v_ram_a)
//   cursor_col  out  5   cursor column
//   cursor_row  out  6   cursor row
//   busy        out  1   high whenever the block is not idle
// -----------------------------------------------------------------------------
module text_writer #(
    parameter int unsigned ROWS  = 16,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [10:0] v_ram_a,
    output logic [7:0]  v_ram_do,
    output logic        v_ram_we,
    input  logic [7:0]  v_ram_di,
    output logic [4:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic        busy
);

    localparam logic [7:0]  CODE_BS     = 8'h08;
    localparam logic [7:0]  CODE_LF     = 8'h0A;
    localparam logic [7:0]  CODE_FF     = 8'h0C;
    localparam logic [7:0]  CODE_CR     = 8'h0D;
    localparam logic [10:0] SCREEN_LAST = 11'(32 * ROWS - 1);
    localparam logic [5:0]  LAST_ROW    = 6'(ROWS - 1);

`ifdef TEXT_WRITER_SCROLL_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUT      = 3'd1,
        ST_SC_RD    = 3'd2,
        ST_SC_WR    = 3'd3,
        ST_CLR_LINE = 3'd4,
        ST_CLR_ALL  = 3'd5
    } state_t;

    // Last destination address of the row copy; the copy index then runs
    // straight on into the last-row clear.
    localparam int          COPY_CELLS = 32 * (int'(ROWS) - 1);
    localparam logic [10:0] COPY_LAST  = 11'(COPY_CELLS - 1);
    // A one-row screen has nothing to copy, so it goes straight to the clear.
    localparam state_t      OVF_STATE  = (ROWS > 1) ? ST_SC_RD : ST_CLR_LINE;
    localparam logic [5:0]  OVF_ROW    = LAST_ROW;
`else
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUT      = 3'd1,
        ST_CLR_LINE = 3'd4,
        ST_CLR_ALL  = 3'd5
    } state_t;

    localparam state_t      OVF_STATE  = ST_CLR_LINE;
    localparam logic [5:0]  OVF_ROW    = 6'd0;

    // Read data is only needed by the scroll copy.
    logic unused_di_s;
    assign unused_di_s = ^v_ram_di;
`endif

    // Linear cell address: row in the upper bits, column in the lower five.
    function automatic logic [10:0] cell_addr(input logic [4:0] col, input logic [5:0] row);
        return {row, col};
    endfunction

    state_t      state_r,  state_nx_s;
    logic [10:0] idx_r,    idx_nx_s;
    logic [4:0]  col_r,    col_nx_s;
    logic [5:0]  row_r,    row_nx_s;
    logic [7:0]  char_r,   char_nx_s;
    logic        adv_r,    adv_nx_s;
    // Low during reset and for the first edge after it, so the clear at
    // index 0 reaches the registered outputs before the index moves on.
    logic        active_r;

    logic [10:0] a_r,      a_nx_s;
    logic [7:0]  do_r,     do_nx_s;
    logic        we_r,     we_nx_s;
    logic        ready_r,  ready_nx_s;
    logic        busy_r,   busy_nx_s;
`ifdef TEXT_WRITER_SCROLL_EN
    logic        sc_wr_r,  sc_wr_nx_s;
`endif

    // Next-state, index and cursor logic
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        col_nx_s   = col_r;
        row_nx_s   = row_r;
        char_nx_s  = char_r;
        adv_nx_s   = adv_r;
        if (!active_r) begin
            state_nx_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && ready_r) begin
                        case (in_data)
                            CODE_CR: begin
                                col_nx_s = 5'd0;
                            end
                            CODE_LF: begin
                                if (row_r == LAST_ROW) begin
                                    state_nx_s = OVF_STATE;
                                    idx_nx_s   = 11'd0;
                                    row_nx_s   = OVF_ROW;
                                end else begin
                                    row_nx_s = row_r + 6'd1;
                                end
                            end
                            CODE_BS: begin
                                // Step back first; PUT then blanks the new cell
                                // without advancing again.
                                if (col_r != 5'd0) begin
                                    col_nx_s   = col_r - 5'd1;
                                    char_nx_s  = BLANK;
                                    adv_nx_s   = 1'b0;
                                    state_nx_s = ST_PUT;
                                end else begin
                                    col_nx_s = col_r;
                                end
                            end
                            CODE_FF: begin
                                col_nx_s   = 5'd0;
                                row_nx_s   = 6'd0;
                                idx_nx_s   = 11'd0;
                                state_nx_s = ST_CLR_ALL;
                            end
                            default: begin
                                char_nx_s  = in_data;
                                adv_nx_s   = 1'b1;
                                state_nx_s = ST_PUT;
                            end
                        endcase
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_PUT: begin
                    state_nx_s = ST_IDLE;
                    if (adv_r) begin
                        if (col_r == 5'd31) begin
                            col_nx_s = 5'd0;
                            if (row_r == LAST_ROW) begin
                                state_nx_s = OVF_STATE;
                                idx_nx_s   = 11'd0;
                                row_nx_s   = OVF_ROW;
                            end else begin
                                row_nx_s = row_r + 6'd1;
                            end
                        end else begin
                            col_nx_s = col_r + 5'd1;
                        end
                    end else begin
                        col_nx_s = col_r;
                    end
                end
`ifdef TEXT_WRITER_SCROLL_EN
                ST_SC_RD: begin
                    state_nx_s = ST_SC_WR;
                end
                ST_SC_WR: begin
                    idx_nx_s = idx_r + 11'd1;
                    if (idx_r == COPY_LAST) begin
                        state_nx_s = ST_CLR_LINE;
                    end else begin
                        state_nx_s = ST_SC_RD;
                    end
                end
`endif
                ST_CLR_LINE: begin
                    // idx holds absolute addresses; the row ends at column 31.
                    if (idx_r[4:0] == 5'd31) begin
                        idx_nx_s   = 11'd0;
                        state_nx_s = ST_IDLE;
                    end else begin
                        idx_nx_s = idx_r + 11'd1;
                    end
                end
                ST_CLR_ALL: begin
                    if (idx_r == SCREEN_LAST) begin
                        idx_nx_s   = 11'd0;
                        state_nx_s = ST_IDLE;
                    end else begin
                        idx_nx_s = idx_r + 11'd1;
                    end
                end
                default: begin
                    // Unreachable encodings recover through a full clear.
                    col_nx_s   = 5'd0;
                    row_nx_s   = 6'd0;
                    idx_nx_s   = 11'd0;
                    state_nx_s = ST_CLR_ALL;
                end
            endcase
        end
    end

    // RAM port values for the state being entered, registered alongside it
    always_comb begin
        a_nx_s     = 11'd0;
        do_nx_s    = BLANK;
        we_nx_s    = 1'b0;
`ifdef TEXT_WRITER_SCROLL_EN
        sc_wr_nx_s = 1'b0;
`endif
        case (state_nx_s)
            ST_IDLE: begin
                we_nx_s = 1'b0;
            end
            ST_PUT: begin
                a_nx_s  = cell_addr(col_nx_s, row_nx_s);
                do_nx_s = char_nx_s;
                we_nx_s = 1'b1;
            end
`ifdef TEXT_WRITER_SCROLL_EN
            ST_SC_RD: begin
                a_nx_s = idx_nx_s + 11'd32;
            end
            ST_SC_WR: begin
                a_nx_s     = idx_nx_s;
                we_nx_s    = 1'b1;
                sc_wr_nx_s = 1'b1;
            end
`endif
            ST_CLR_LINE, ST_CLR_ALL: begin
                a_nx_s  = idx_nx_s;
                we_nx_s = 1'b1;
            end
            default: begin
                we_nx_s = 1'b0;
            end
        endcase
        ready_nx_s = (state_nx_s == ST_IDLE);
        busy_nx_s  = (state_nx_s != ST_IDLE);
    end

    // State, cursor and output registers
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_r  <= ST_CLR_ALL;
            idx_r    <= 11'd0;
            col_r    <= 5'd0;
            row_r    <= 6'd0;
            char_r   <= BLANK;
            adv_r    <= 1'b0;
            active_r <= 1'b0;
            a_r      <= 11'd0;
            do_r     <= BLANK;
            we_r     <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b1;
`ifdef TEXT_WRITER_SCROLL_EN
            sc_wr_r  <= 1'b0;
`endif
        end else begin
            state_r  <= state_nx_s;
            idx_r    <= idx_nx_s;
            col_r    <= col_nx_s;
            row_r    <= row_nx_s;
            char_r   <= char_nx_s;
            adv_r    <= adv_nx_s;
            active_r <= 1'b1;
            a_r      <= a_nx_s;
            do_r     <= do_nx_s;
            we_r     <= we_nx_s;
            ready_r  <= ready_nx_s;
            busy_r   <= busy_nx_s;
`ifdef TEXT_WRITER_SCROLL_EN
            sc_wr_r  <= sc_wr_nx_s;
`endif
        end
    end

    assign in_ready   = ready_r;
    assign busy       = busy_r;
    assign v_ram_a    = a_r;
    assign v_ram_we   = we_r;
    assign cursor_col = col_r;
    assign cursor_row = row_r;
`ifdef TEXT_WRITER_SCROLL_EN
    // The copy write forwards the word read in the preceding SC_RD cycle.
    assign v_ram_do   = sc_wr_r ? v_ram_di : do_r;
`else
    assign v_ram_do   = do_r;
`endif

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 Parameter ROWS, 16, number of text rows on screen, 1..64.
REQ-002 Parameter BLANK, 8'h20, character code used to clear a cell.
REQ-003 The row stride SHALL be fixed at 32 cells, so cell (col,row) maps to address row*32+col.
REQ-004 clk_sys  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  8  character or control code.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block can accept a byte this cycle.
REQ-009 v_ram_a  output  11  video RAM address.
REQ-010 v_ram_do  output  8  video RAM write data.
REQ-011 v_ram_we  output  1  video RAM write enable.
REQ-012 v_ram_di  input  8  video RAM read data, valid one cycle after v_ram_a is presented.
REQ-013 cursor_col  output  5  current column.
REQ-014 cursor_row  output  6  current row.
REQ-015 busy  output  1  high in every state other than IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, PUT, SC_RD, SC_WR, CLR_LINE and CLR_ALL.
REQ-017 in_ready SHALL be 1 only in IDLE; a byte is accepted on the cycle in_valid&&in_ready, and IDLE is left on the next edge.
REQ-018 A printable byte (0x20..0xFF, or 0x00..0x1F other than the codes in REQ-020..REQ-023) SHALL be latched and cause PUT for exactly one cycle: v_ram_we=1, v_ram_a=cursor address, v_ram_do=byte.
REQ-019 After PUT, the cursor SHALL advance col+1; at col 31 it becomes col 0, row+1; if row was ROWS-1, the row stays ROWS-1 and the FSM enters SC_RD, otherwise IDLE.
REQ-020 0x0D (CR) SHALL set col=0 with no RAM write and return to IDLE the next cycle.
REQ-021 0x0A (LF) SHALL set row+1 with col unchanged; at row ROWS-1 it SHALL scroll instead.
REQ-022 0x08 (BS) at col>0 SHALL set col-1 and then PUT BLANK at the new position; at col 0 it SHALL be a no-op.
REQ-023 0x0C (FF) SHALL enter CLR_ALL and home the cursor to (0,0).
REQ-024 Scroll: for i = 0 .. 32*(ROWS-1)-1, SC_RD SHALL drive v_ram_a=i+32 with we=0, and SC_WR SHALL drive v_ram_a=i, v_ram_do=v_ram_di, we=1.
REQ-025 Scroll SHALL then enter CLR_LINE, which writes BLANK to addresses 32*(ROWS-1) .. 32*ROWS-1 at one per cycle, then goes to IDLE.
REQ-026 Total scroll duration SHALL be 64*(ROWS-1)+32 cycles.
REQ-027 CLR_ALL SHALL write BLANK to addresses 0 .. 32*ROWS-1 at one per cycle (32*ROWS cycles), then go to IDLE.
REQ-028 v_ram_we SHALL be 0 in IDLE and SC_RD; v_ram_a SHALL never exceed 32*ROWS-1.
REQ-029 in_valid while busy SHALL be ignored; the byte is not consumed and the source must hold it.

Reset
REQ-030 While rst=1: state=CLR_ALL with index 0, cursor=(0,0), v_ram_we=0, in_ready=0, busy=1.
REQ-031 After rst falls, the full-screen clear (REQ-027) SHALL run before the first byte is accepted.
REQ-032 rst asserted mid-scroll or mid-clear SHALL abort immediately and restart per REQ-030.

Configuration
REQ-033 Macro TEXT_WRITER_SCROLL_EN: when defined, overflow past row ROWS-1 SHALL scroll per REQ-024..REQ-026.
REQ-034 When TEXT_WRITER_SCROLL_EN is undefined, overflow SHALL instead set row=0 and run CLR_LINE on row 0 only (32 cycles); SC_RD and SC_WR SHALL be absent.

Verification
REQ-035 Reset release -> 512 consecutive BLANK writes at addresses 0..511 (ROWS=16), then in_ready=1, cursor=(0,0).
REQ-036 Send 'A' (0x41) at cursor (3,2) -> one write at address 67 with data 0x41; cursor becomes (4,2); in_ready returns to 1 two cycles after acceptance.
REQ-037 Send 33 printable bytes from (0,0) -> the 33rd byte is written at address 32; cursor becomes (1,1).
REQ-038 Send LF at row 15 with SCROLL_EN defined -> 992 busy cycles; RAM[0..479] equals the former RAM[32..511]; RAM[480..511]=0x20; cursor row=15.
REQ-039 Send BS at (0,5) -> no write and cursor unchanged; send BS at (7,5) -> write 0x20 at address 166 and cursor becomes (6,5).
REQ-040 Assert rst at scroll cycle 100 -> v_ram_we drops to 0 asynchronously; after release, a full 512-cycle clear runs and cursor=(0,0).
